// File: rtl/pic_pkg.sv
// Shared constants, types and branch decode for the 14-bit PIC-style core.
package pic_pkg;

  localparam int unsigned PC_W        = 11;
  localparam int unsigned INSN_W      = 14;
  localparam int unsigned STACK_DEPTH = 8;

  typedef logic [10:0] pc_t;
  typedef logic [13:0] insn_t;

  localparam insn_t NOP          = 14'h0000;
  localparam insn_t GOTO_MASK    = 14'h3800;
  localparam insn_t GOTO_MATCH   = 14'h2800;
  localparam insn_t CALL_MASK    = 14'h3800;
  localparam insn_t CALL_MATCH   = 14'h2000;
  localparam insn_t RETURN_MASK  = 14'h3FFF;
  localparam insn_t RETURN_MATCH = 14'h0008;
  localparam insn_t RETLW_MASK   = 14'h3C00;
  localparam insn_t RETLW_MATCH  = 14'h3400;

  typedef enum logic [2:0] {
    BR_NONE,
    BR_GOTO,
    BR_CALL,
    BR_RETURN,
    BR_RETLW
  } branch_e;

  function automatic branch_e decode_branch(input insn_t insn);
    branch_e br;
    br = BR_NONE;
    if ((insn & GOTO_MASK) == GOTO_MATCH)          br = BR_GOTO;
    else if ((insn & CALL_MASK) == CALL_MATCH)     br = BR_CALL;
    else if ((insn & RETURN_MASK) == RETURN_MATCH) br = BR_RETURN;
    else if ((insn & RETLW_MASK) == RETLW_MATCH)   br = BR_RETLW;
    return br;
  endfunction

endpackage

// File: rtl/pic_return_stack.sv
// Circular hardware return stack with saturating occupancy count and sticky
// overflow/underflow flags.
module pic_return_stack #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 11
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] data_in,
  output logic [W-1:0] data_out,
  output logic         ovf,
  output logic         unf
);

  localparam int unsigned SP_W = $clog2(DEPTH);
  localparam logic [SP_W:0] FULL = DEPTH[SP_W:0];

  logic [W-1:0]    mem_q [DEPTH];
  logic [SP_W-1:0] sp_q;
  logic [SP_W-1:0] sp_dec;
  logic [SP_W:0]   count_q;
  logic            ovf_q;
  logic            unf_q;

  // Top-of-stack is always entry[sp-1]; an underflowing pop returns it stale.
  assign sp_dec   = sp_q - 1'b1;
  assign data_out = mem_q[sp_dec];
  assign ovf      = ovf_q;
  assign unf      = unf_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[sp_q] <= data_in;
      sp_q        <= sp_q + 1'b1;
      if (count_q == FULL) ovf_q <= 1'b1;
      else                 count_q <= count_q + 1'b1;
    end else if (pop) begin
      sp_q <= sp_dec;
      if (count_q == '0) unf_q <= 1'b1;
      else               count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/pic_fetch_unit.sv
// Fetch stage: program counter, instruction register and GOTO/CALL/RETURN/RETLW
// resolution with execute-requested skip and a global stall.
module pic_fetch_unit #(
  parameter int unsigned PC_W        = 11,
  parameter int unsigned INSN_W      = 14,
  parameter int unsigned STACK_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              skip,
  output logic [PC_W-1:0]   Rom_addr_out,
  input  logic [INSN_W-1:0] Rom_data_in,
  output logic [INSN_W-1:0] ir_out,
  output logic              ir_valid,
  output logic [PC_W-1:0]   pc_out,
  output logic              stack_ovf,
  output logic              stack_unf
);

  import pic_pkg::*;

  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   pc_out_q, pc_out_d;
  logic [INSN_W-1:0] ir_q, ir_d;
  logic              ir_valid_q, ir_valid_d;
  logic [PC_W-1:0]   pc_inc;
  logic [PC_W-1:0]   stack_top;
  logic              push, pop;
  branch_e           br;

  pic_return_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (PC_W)
  ) u_stack (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .data_in  (pc_q),
    .data_out (stack_top),
    .ovf      (stack_ovf),
    .unf      (stack_unf)
  );

  // Inserted bubbles (ir_valid=0) never decode as branches.
  assign br     = ir_valid_q ? decode_branch(ir_q) : BR_NONE;
  assign pc_inc = pc_q + 1'b1;
  assign push   = !stall && (br == BR_CALL);
  assign pop    = !stall && (br == BR_RETURN || br == BR_RETLW);

  always_comb begin
    pc_d       = pc_q;
    pc_out_d   = pc_out_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    if (!stall) begin
      pc_out_d = pc_q;
      if (br != BR_NONE) begin
        ir_d       = NOP;
        ir_valid_d = 1'b0;
        if (br == BR_GOTO || br == BR_CALL) pc_d = ir_q[PC_W-1:0];
        else                                pc_d = stack_top;
      end else if (skip) begin
        ir_d       = NOP;
        ir_valid_d = 1'b0;
        pc_d       = pc_inc;
      end else begin
        ir_d       = Rom_data_in;
        ir_valid_d = 1'b1;
        pc_d       = pc_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= '0;
      pc_out_q   <= '0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pc_out_q   <= pc_out_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  assign Rom_addr_out = pc_q;
  assign ir_out       = ir_q;
  assign ir_valid     = ir_valid_q;
  assign pc_out       = pc_out_q;

endmodule

// File: tb/tb_pic_fetch_unit.sv
// Directed bench for pic_fetch_unit: per-test expected IR stream queued up
// front, popped and checked one clock at a time against the DUT.
module tb_pic_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, stall, skip;
  logic [10:0] Rom_addr_out;
  logic [13:0] Rom_data_in;
  logic [13:0] ir_out;
  logic        ir_valid;
  logic [10:0] pc_out;
  logic        stack_ovf, stack_unf;

  logic [13:0] rom [0:2047];

  typedef struct {
    logic [13:0] ir;
    logic        valid;
    logic [10:0] pc;
  } exp_t;

  exp_t        sb[$];
  logic [10:0] pq[$];
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  assign Rom_data_in = rom[Rom_addr_out];

  pic_fetch_unit #(
    .PC_W        (11),
    .INSN_W      (14),
    .STACK_DEPTH (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .skip         (skip),
    .Rom_addr_out (Rom_addr_out),
    .Rom_data_in  (Rom_data_in),
    .ir_out       (ir_out),
    .ir_valid     (ir_valid),
    .pc_out       (pc_out),
    .stack_ovf    (stack_ovf),
    .stack_unf    (stack_unf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 2048; i++) rom[i] = 14'h0000;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    stall = 1'b0;
    skip  = 1'b0;
    tick();
    tick();
    check("rst ir_out",   32'(ir_out),       32'h0);
    check("rst ir_valid", 32'(ir_valid),     32'h0);
    check("rst pc_out",   32'(pc_out),       32'h0);
    check("rst rom_addr", 32'(Rom_addr_out), 32'h0);
    check("rst ovf",      32'(stack_ovf),    32'h0);
    check("rst unf",      32'(stack_unf),    32'h0);
    reset = 1'b0;
  endtask

  task automatic exp_push(input logic [13:0] ir, input logic valid, input logic [10:0] pc);
    exp_t e;
    e.ir    = ir;
    e.valid = valid;
    e.pc    = pc;
    sb.push_back(e);
  endtask

  task automatic step_check(input string tag);
    exp_t e;
    tick();
    e = sb.pop_front();
    check({tag, " ir"},    32'(ir_out),   32'(e.ir));
    check({tag, " valid"}, 32'(ir_valid), 32'(e.valid));
    if (e.valid) check({tag, " pc_out"}, 32'(pc_out), 32'(e.pc));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=hang expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    skip  = 1'b0;

    // Straight-line fetch
    clear_rom();
    rom[0] = 14'h3001; rom[1] = 14'h3E02; rom[2] = 14'h3003; rom[3] = 14'h3004;
    do_reset();
    exp_push(14'h3001, 1'b1, 11'd0);
    exp_push(14'h3E02, 1'b1, 11'd1);
    exp_push(14'h3003, 1'b1, 11'd2);
    exp_push(14'h3004, 1'b1, 11'd3);
    repeat (4) step_check("t1");

    // GOTO 5, with a skip raised while the GOTO sits in IR (must be ignored)
    clear_rom();
    rom[0] = 14'h3001; rom[1] = 14'h3E02; rom[2] = 14'h2805;
    rom[5] = 14'h3055; rom[6] = 14'h3006;
    do_reset();
    exp_push(14'h3001, 1'b1, 11'd0);
    exp_push(14'h3E02, 1'b1, 11'd1);
    exp_push(14'h2805, 1'b1, 11'd2);
    exp_push(14'h0000, 1'b0, 11'd0);
    exp_push(14'h3055, 1'b1, 11'd5);
    exp_push(14'h3006, 1'b1, 11'd6);
    repeat (3) step_check("t2");
    skip = 1'b1;
    step_check("t2 bubble");
    skip = 1'b0;
    repeat (2) step_check("t2");

    // CALL 0x10 / RETURN, one bubble each
    clear_rom();
    rom[0] = 14'h3001; rom[1] = 14'h2010; rom[2] = 14'h3003; rom[16] = 14'h0008;
    do_reset();
    exp_push(14'h3001, 1'b1, 11'd0);
    exp_push(14'h2010, 1'b1, 11'd1);
    exp_push(14'h0000, 1'b0, 11'd0);
    exp_push(14'h0008, 1'b1, 11'h010);
    exp_push(14'h0000, 1'b0, 11'd0);
    exp_push(14'h3003, 1'b1, 11'd2);
    repeat (6) step_check("t3");

    // Skip squashes ROM[4]
    clear_rom();
    for (int i = 0; i < 8; i++) rom[i] = 14'h3000 + 14'(i);
    do_reset();
    for (int i = 0; i < 4; i++) exp_push(14'h3000 + 14'(i), 1'b1, 11'(i));
    repeat (4) step_check("t4");
    skip = 1'b1;
    exp_push(14'h0000, 1'b0, 11'd0);
    step_check("t4 skip");
    skip = 1'b0;
    exp_push(14'h3005, 1'b1, 11'd5);
    exp_push(14'h3006, 1'b1, 11'd6);
    repeat (2) step_check("t4");

    // Stall held three clocks
    do_reset();
    exp_push(14'h3000, 1'b1, 11'd0);
    exp_push(14'h3001, 1'b1, 11'd1);
    repeat (2) step_check("t5");
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_push(14'h3001, 1'b1, 11'd1);
      step_check("t5 stall");
      check("t5 stall rom_addr", 32'(Rom_addr_out), 32'd2);
    end
    stall = 1'b0;
    exp_push(14'h3002, 1'b1, 11'd2);
    exp_push(14'h3003, 1'b1, 11'd3);
    repeat (2) step_check("t5");

    // Nine nested CALLs, RETURN chain, then one extra RETURN underflows
    clear_rom();
    rom[0] = 14'h2900;
    for (int i = 0; i < 9; i++) begin
      rom[11'h100 + 11'(2*i)] = 14'h2000 | 14'(11'h102 + 11'(2*i));
      rom[11'h101 + 11'(2*i)] = 14'h0008;
    end
    rom[11'h112] = 14'h0008;
    do_reset();
    pq.push_back(11'h000);
    for (int i = 0; i < 10; i++) pq.push_back(11'h100 + 11'(2*i));
    for (int i = 0; i < 8; i++)  pq.push_back(11'h111 - 11'(2*i));
    pq.push_back(11'h111);
    for (int idx = 0; pq.size() > 0; idx++) begin
      logic [10:0] target;
      int          n;
      target = pq.pop_front();
      n = 0;
      do begin
        tick();
        n++;
      end while (!ir_valid && n < 4);
      check("t6 valid", 32'(ir_valid), 32'd1);
      check("t6 landing", 32'(pc_out), 32'(target));
      if (idx == 9)  check("t6 ovf before 9th call", 32'(stack_ovf), 32'd0);
      if (idx == 10) check("t6 ovf after 9th call",  32'(stack_ovf), 32'd1);
      if (idx == 10) check("t6 unf after 9th call",  32'(stack_unf), 32'd0);
      if (idx == 18) check("t6 unf after 8 returns", 32'(stack_unf), 32'd0);
      if (idx == 19) check("t6 unf after extra ret", 32'(stack_unf), 32'd1);
    end
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
